// File: rtl/temp_ctrl_fsm.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | temp_ctrl_fsm                                                            |
// | Thermostat decision FSM: hysteresis, debounce, min on-time, sensor fault |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module temp_ctrl_fsm #(
    parameter int TEMP_W         = 12,
    parameter int CONFIRM_CNT    = 4,
    parameter int MIN_ON_CYCLES  = 50_000_000,
    parameter int TIMEOUT_CYCLES = 200_000_000
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              enable,
    input  logic              temp_valid,
    input  logic [TEMP_W-1:0] temp_data,
    input  logic [TEMP_W-1:0] hi_thresh,
    input  logic [TEMP_W-1:0] lo_thresh,
    input  logic [TEMP_W-1:0] hyst,
    output logic              fan_en,
    output logic              heater_en,
    output logic [1:0]        state,
    output logic              sensor_fault,
    output logic              cfg_err
);

    localparam int QW = $clog2(CONFIRM_CNT + 1);
    localparam int OW = $clog2(MIN_ON_CYCLES + 2);
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [QW-1:0] Q_FULL  = QW'(CONFIRM_CNT);
    localparam logic [QW-1:0] Q_ONE   = QW'(1);
    localparam logic [OW-1:0] ON_FULL = OW'(MIN_ON_CYCLES);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_COOL  = 2'b01,
        ST_HEAT  = 2'b10,
        ST_FAULT = 2'b11
    } state_t;

    state_t            cur_state;
    state_t            next_state;
    logic [QW-1:0]     qcnt;
    logic [QW-1:0]     qcnt_next;
    logic [QW-1:0]     qcnt_inc;
    logic              dir_heat;
    logic              dir_heat_next;
    logic [OW-1:0]     on_cnt;
    logic [WW-1:0]     wd_cnt;
    logic [TEMP_W:0]   cool_diff;
    logic [TEMP_W:0]   heat_sum;
    logic [TEMP_W-1:0] cool_exit;
    logic [TEMP_W-1:0] heat_exit;
    logic              want_cool;
    logic              want_heat;
    logic              cool_ok;
    logic              heat_ok;
    logic              min_on_done;
    logic              wd_expire;

    assign cfg_err   = (lo_thresh >= hi_thresh);
    assign state     = cur_state;

    // Exit bounds use one extra bit so the hysteresis band clamps instead of wrapping
    assign cool_diff = {1'b0, hi_thresh} - {1'b0, hyst};
    assign heat_sum  = {1'b0, lo_thresh} + {1'b0, hyst};
    assign cool_exit = cool_diff[TEMP_W] ? '0 : cool_diff[TEMP_W-1:0];
    assign heat_exit = heat_sum[TEMP_W]  ? '1 : heat_sum[TEMP_W-1:0];

    assign want_cool   = (temp_data > hi_thresh);
    assign want_heat   = (temp_data < lo_thresh);
    assign cool_ok     = (temp_data <= cool_exit);
    assign heat_ok     = (temp_data >= heat_exit);
    assign qcnt_inc    = (qcnt == Q_FULL) ? Q_FULL : qcnt + 1'b1;
    assign min_on_done = (on_cnt >= ON_FULL);
    assign wd_expire   = !temp_valid && (wd_cnt == WD_LAST);

    always_comb begin
        next_state    = cur_state;
        qcnt_next     = qcnt;
        dir_heat_next = dir_heat;
        if (cur_state != ST_FAULT && wd_expire) begin
            next_state = ST_FAULT;
        end else begin
            case (cur_state)
                ST_IDLE: begin
                    if (temp_valid) begin
                        // One shared counter: switching direction restarts the count
                        if (want_cool) begin
                            qcnt_next     = dir_heat ? Q_ONE : qcnt_inc;
                            dir_heat_next = 1'b0;
                        end else if (want_heat) begin
                            qcnt_next     = dir_heat ? qcnt_inc : Q_ONE;
                            dir_heat_next = 1'b1;
                        end else begin
                            qcnt_next = '0;
                        end
                        if (qcnt_next == Q_FULL && !cfg_err) begin
                            next_state = dir_heat_next ? ST_HEAT : ST_COOL;
                        end
                    end
                end
                ST_COOL: begin
                    if (cfg_err) begin
                        next_state = ST_IDLE;
                    end else if (temp_valid) begin
                        qcnt_next = cool_ok ? qcnt_inc : '0;
                        if (qcnt_next == Q_FULL && min_on_done) begin
                            next_state = ST_IDLE;
                        end
                    end
                end
                ST_HEAT: begin
                    if (cfg_err) begin
                        next_state = ST_IDLE;
                    end else if (temp_valid) begin
                        qcnt_next = heat_ok ? qcnt_inc : '0;
                        if (qcnt_next == Q_FULL && min_on_done) begin
                            next_state = ST_IDLE;
                        end
                    end
                end
                default: begin
                    if (temp_valid) begin
                        next_state = ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (!presetn || !enable) begin
            cur_state    <= ST_IDLE;
            fan_en       <= 1'b0;
            heater_en    <= 1'b0;
            sensor_fault <= 1'b0;
            qcnt         <= '0;
            dir_heat     <= 1'b0;
            on_cnt       <= '0;
            wd_cnt       <= '0;
        end else begin
            cur_state    <= next_state;
            fan_en       <= (next_state == ST_COOL);
            heater_en    <= (next_state == ST_HEAT);
            sensor_fault <= (next_state == ST_FAULT);
            dir_heat     <= dir_heat_next;
            if (next_state != cur_state) begin
                qcnt   <= '0;
                on_cnt <= '0;
            end else begin
                qcnt <= qcnt_next;
                if (on_cnt != ON_FULL) begin
                    on_cnt <= on_cnt + 1'b1;
                end
            end
            if (temp_valid) begin
                wd_cnt <= '0;
            end else if (wd_cnt != WD_LAST) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
